// File: rtl/cpu_control_fsm.sv
`timescale 1ns/1ps
// cpu_control_fsm
// Sequencing controller for the mini CPU datapath. Debounces the active-low
// Enviar button and turns each accepted release into one instruction pass:
// LATCH -> EXEC -> WRITE -> DISP_REQ -> DISP_WAIT -> IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   enviar       raw Enviar button, active low, asynchronous to clk
//   opcode[2:0]  instruction opcode (switches[17:15])
//   lcd_done     one-cycle completion pulse from the LCD driver
//   ready        high only in IDLE
//   instr_latch  one-cycle strobe to capture the instruction
//   reg_write    one-cycle register-file write enable (opcodes 000-101)
//   clear_regs   one-cycle register-file clear (opcode 110)
//   lcd_start    one-cycle request to the LCD driver
//   lcd_op[2:0]  opcode of the current pass, held until the next LATCH
//   lcd_timeout  sticky: last pass was abandoned by timeout
//   instr_count  completed passes, wraps 255 -> 0
module cpu_control_fsm #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LCD_TIMEOUT     = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enviar,
    input  logic [2:0] opcode,
    input  logic       lcd_done,
    output logic       ready,
    output logic       instr_latch,
    output logic       reg_write,
    output logic       clear_regs,
    output logic       lcd_start,
    output logic [2:0] lcd_op,
    output logic       lcd_timeout,
    output logic [7:0] instr_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(LCD_TIMEOUT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LCD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EXEC,
        S_WRITE,
        S_DISP_REQ,
        S_DISP_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            acc_q;      // accepted (debounced) button level
    logic [DW-1:0]   db_cnt;
    logic            rel_q;      // one-cycle release event
    logic [2:0]      op_q;
    logic [TW-1:0]   to_cnt;
    logic            timeout_hit;

    // Button path: 2-flop synchronizer, then the level must differ from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles to be taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            acc_q  <= 1'b1;
            db_cnt <= '0;
            rel_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], enviar};
            rel_q  <= 1'b0;
            if (sync_q[1] == acc_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                acc_q  <= sync_q[1];
                db_cnt <= '0;
                rel_q  <= sync_q[1];   // only a 0->1 acceptance is a release
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (rel_q) state_d = S_LATCH;
            S_LATCH:     state_d = S_EXEC;
            S_EXEC:      state_d = S_WRITE;
            S_WRITE:     state_d = S_DISP_REQ;
            S_DISP_REQ:  state_d = S_DISP_WAIT;
            S_DISP_WAIT: if (lcd_done || timeout_hit) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so every output comes
    // straight off a flop, and an async reset clears them the same instant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready       <= 1'b1;
            instr_latch <= 1'b0;
            reg_write   <= 1'b0;
            clear_regs  <= 1'b0;
            lcd_start   <= 1'b0;
        end else begin
            ready       <= (state_d == S_IDLE);
            instr_latch <= (state_d == S_LATCH);
            // op_q is loaded at the end of LATCH, well before WRITE is entered
            reg_write   <= (state_d == S_WRITE) && (op_q <= 3'd5);
            clear_regs  <= (state_d == S_WRITE) && (op_q == 3'd6);
            lcd_start   <= (state_d == S_DISP_REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= 3'd0;
            to_cnt      <= '0;
            lcd_timeout <= 1'b0;
            instr_count <= 8'd0;
        end else begin
            case (state_q)
                S_LATCH: begin
                    op_q        <= opcode;
                    lcd_timeout <= 1'b0;
                end
                S_DISP_REQ: to_cnt <= '0;
                S_DISP_WAIT: begin
                    if (lcd_done || timeout_hit) begin
                        instr_count <= instr_count + 8'd1;
                        lcd_timeout <= ~lcd_done;   // done wins a tie
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lcd_op = op_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    localparam int DEB = 4;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enviar;
    logic [2:0] opcode;
    logic       lcd_done;
    logic       ready, instr_latch, reg_write, clear_regs, lcd_start, lcd_timeout;
    logic [2:0] lcd_op;
    logic [7:0] instr_count;

    cpu_control_fsm #(.DEBOUNCE_CYCLES(DEB), .LCD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enviar(enviar), .opcode(opcode),
        .lcd_done(lcd_done), .ready(ready), .instr_latch(instr_latch),
        .reg_write(reg_write), .clear_regs(clear_regs), .lcd_start(lcd_start),
        .lcd_op(lcd_op), .lcd_timeout(lcd_timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int fails = 0;

    // reference model state
    logic [7:0] exp_count;
    logic       exp_to;

    // strobe monitor (samples mid-cycle)
    int cyc = 0;
    int n_latch = 0, n_rw = 0, n_clr = 0, n_start = 0;
    int latch_cyc = 0, rw_cyc = 0, clr_cyc = 0, start_cyc = 0;
    logic [2:0] start_op;
    logic       start_to;

    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (instr_latch) begin n_latch++; latch_cyc = cyc; end
            if (reg_write)   begin n_rw++;    rw_cyc = cyc;    end
            if (clear_regs)  begin n_clr++;   clr_cyc = cyc;   end
            if (lcd_start)   begin n_start++; start_cyc = cyc; start_op = lcd_op; start_to = lcd_timeout; end
            if (reg_write || clear_regs) begin
                cmp++;
                if (reg_write && clear_regs) begin
                    $display("FAIL excl_write: reg_write=%b clear_regs=%b both high at cycle %0d", reg_write, clear_regs, cyc);
                    fails++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press_release(input bit bouncy);
        enviar = 1'b0;
        repeat (10) tick();
        if (bouncy) begin
            for (int i = 0; i < 10; i++) begin
                enviar = ~enviar;
                repeat (2) tick();
            end
        end
        enviar = 1'b1;
    endtask

    // One full pass driven from the button. dly<0 means lcd_done never comes;
    // otherwise lcd_done is pulsed dly cycles after the lcd_start cycle.
    task automatic run_pass(input logic [2:0] op, input int dly, input bit bouncy, input bit extra_press);
        int b_l, b_rw, b_clr, b_st;
        bit exp_rw, exp_clr;
        b_l = n_latch; b_rw = n_rw; b_clr = n_clr; b_st = n_start;
        exp_rw  = (op <= 3'd5);
        exp_clr = (op == 3'd6);
        opcode = op;
        press_release(bouncy);
        for (int k = 0; k < 60 && n_latch == b_l; k++) tick();
        cmp++;
        if (n_latch == b_l) begin
            $display("FAIL latch_wait: no instr_latch within 60 cycles (op=%0d)", op);
            fails++;
            return;
        end
        cmp++;
        if (ready !== 1'b0) begin
            $display("FAIL ready_in_latch: got %b want 0", ready);
            fails++;
        end
        if (extra_press) begin
            // second release lands while the pass is still in DISP_WAIT
            enviar = 1'b0;
            repeat (6) tick();
            enviar = 1'b1;
        end
        for (int k = 0; k < 10 && n_start == b_st; k++) tick();
        cmp++;
        if (n_start == b_st) begin
            $display("FAIL start_wait: no lcd_start within 10 cycles");
            fails++;
            return;
        end
        if (dly >= 0) begin
            repeat (dly) tick();
            lcd_done = 1'b1;
            tick();
            lcd_done = 1'b0;
            cmp++;
            if (ready !== 1'b1) begin
                $display("FAIL ready_after_done: got %b want 1 (dly=%0d)", ready, dly);
                fails++;
            end
        end else begin
            for (int k = 0; k < 40 && ready !== 1'b1; k++) tick();
            cmp++;
            if (cyc - start_cyc !== TO + 1) begin
                $display("FAIL timeout_len: ready %0d cycles after lcd_start, want %0d", cyc - start_cyc, TO + 1);
                fails++;
            end
        end
        exp_count = exp_count + 8'd1;
        exp_to    = (dly < 0);

        cmp++;
        if (instr_count !== exp_count) begin
            $display("FAIL instr_count: got %0d want %0d", instr_count, exp_count);
            fails++;
        end
        cmp++;
        if (lcd_timeout !== exp_to) begin
            $display("FAIL lcd_timeout: got %b want %b (dly=%0d)", lcd_timeout, exp_to, dly);
            fails++;
        end
        cmp++;
        if (start_op !== op || lcd_op !== op) begin
            $display("FAIL lcd_op: at start %0d, now %0d, want %0d", start_op, lcd_op, op);
            fails++;
        end
        cmp++;
        if (start_to !== 1'b0) begin
            $display("FAIL timeout_cleared: lcd_timeout=%b during lcd_start, want 0", start_to);
            fails++;
        end
        cmp++;
        if (n_rw - b_rw !== int'(exp_rw) || n_clr - b_clr !== int'(exp_clr)) begin
            $display("FAIL write_kind: op=%0d reg_write x%0d clear_regs x%0d, want x%0d x%0d",
                     op, n_rw - b_rw, n_clr - b_clr, exp_rw, exp_clr);
            fails++;
        end
        cmp++;
        if (exp_rw && rw_cyc - latch_cyc !== 2) begin
            $display("FAIL rw_timing: reg_write %0d after latch, want 2", rw_cyc - latch_cyc);
            fails++;
        end
        if (exp_clr && clr_cyc - latch_cyc !== 2) begin
            $display("FAIL clr_timing: clear_regs %0d after latch, want 2", clr_cyc - latch_cyc);
            fails++;
        end
        cmp++;
        if (start_cyc - latch_cyc !== 3 || n_start - b_st !== 1) begin
            $display("FAIL start_timing: lcd_start %0d after latch (x%0d), want 3 (x1)", start_cyc - latch_cyc, n_start - b_st);
            fails++;
        end
        repeat (12) tick();
        cmp++;
        if (n_latch - b_l !== 1) begin
            $display("FAIL one_pass: %0d passes from one release, want 1", n_latch - b_l);
            fails++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enviar = 1'b1; opcode = 3'd0; lcd_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        exp_count = 8'd0; exp_to = 1'b0;
        cmp++;
        if ({ready, instr_latch, reg_write, clear_regs, lcd_start, lcd_timeout} !== 6'b100000) begin
            $display("FAIL reset_strobes: rdy/lat/rw/clr/st/to=%b want 100000",
                     {ready, instr_latch, reg_write, clear_regs, lcd_start, lcd_timeout});
            fails++;
        end
        cmp++;
        if (lcd_op !== 3'd0 || instr_count !== 8'd0) begin
            $display("FAIL reset_regs: lcd_op=%0d instr_count=%0d want 0 0", lcd_op, instr_count);
            fails++;
        end
    endtask

    task automatic test_basic();
        run_pass(3'b010, 3, 1'b0, 1'b0);
    endtask

    task automatic test_bouncy();
        run_pass(3'($urandom_range(0, 5)), $urandom_range(1, 8), 1'b1, 1'b0);
    endtask

    task automatic test_clear_nop();
        run_pass(3'b110, 2, 1'b0, 1'b0);
        run_pass(3'b111, 2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_pass(3'($urandom_range(0, 7)), -1, 1'b0, 1'b0);
        run_pass(3'($urandom_range(0, 7)), $urandom_range(1, 15), 1'b0, 1'b0);
        // lcd_done on the very cycle the timeout would fire
        run_pass(3'($urandom_range(0, 7)), TO, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int b_st;
        run_pass(3'($urandom_range(0, 7)), -1, 1'b0, 1'b1);
        b_st = n_start;
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        repeat (4) tick();
        cmp++;
        if (ready !== 1'b1 || instr_count !== exp_count || n_start !== b_st) begin
            $display("FAIL stray_done: ready=%b count=%0d starts+%0d, want 1 %0d +0",
                     ready, instr_count, n_start - b_st, exp_count);
            fails++;
        end
    endtask

    task automatic test_reset_exec();
        int b_l, b_rw;
        b_l = n_latch;
        opcode = 3'd3;
        press_release(1'b0);
        for (int k = 0; k < 60 && n_latch == b_l; k++) tick();
        tick();                      // now in EXEC
        reset = 1'b1;
        #1;
        cmp++;
        if ({ready, instr_latch, reg_write, clear_regs, lcd_start, lcd_timeout} !== 6'b100000
            || lcd_op !== 3'd0 || instr_count !== 8'd0) begin
            $display("FAIL reset_exec: rdy/lat/rw/clr/st/to=%b lcd_op=%0d count=%0d want 100000 0 0",
                     {ready, instr_latch, reg_write, clear_regs, lcd_start, lcd_timeout}, lcd_op, instr_count);
            fails++;
        end
        b_rw = n_rw;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        exp_count = 8'd0; exp_to = 1'b0;
        cmp++;
        if (n_rw !== b_rw || ready !== 1'b1) begin
            $display("FAIL no_partial: reg_write x%0d after reset, ready=%b, want x0 1", n_rw - b_rw, ready);
            fails++;
        end
    endtask

    task automatic test_wrap();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, TO);
            run_pass(3'($urandom_range(0, 7)), (r == 0) ? -1 : r, 1'b0, 1'b0);
        end
        cmp++;
        if (instr_count !== 8'd0) begin
            $display("FAIL wrap: instr_count=%0d after 256 passes, want 0", instr_count);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bouncy();
        test_clear_nop();
        test_timeout();
        test_back_to_back();
        test_reset_exec();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
